key_debounce: RTL

KEY_DEBOUNCE -- requirements
Module: key_debounce

---
 rtl/key_debounce_pkg.sv | 7 +
 rtl/key_debounce_cell.sv | 52 +++++
 rtl/key_debounce.sv | 29 ++
 3 files changed

// File: rtl/key_debounce_pkg.sv
// key_debounce_pkg: shared default debounce interval and counter sizing helper.
package key_debounce_pkg;
    localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;
    function automatic int cnt_width(input int cycles);
        return (cycles > 2) ? $clog2(cycles) : 1;
    endfunction
endpackage

// File: rtl/key_debounce_cell.sv
// key_debounce_cell: one pushbutton channel -- synchronizer, stability counter, level, pulses, sticky press flag.
module key_debounce_cell
    import key_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    input  logic clear_edge,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse,
    output logic edge_capture
);
    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    logic [1:0]    sync_q;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pressed_q, press_q, release_q, cap_q;
    logic          differ;
    // stable_q keeps the raw pin polarity (1 = released); the toggle clears the counter
    always_comb begin
        differ   = sync_q[1] != stable_q;
        cnt_d    = (differ && cnt_q != CNT_LAST) ? cnt_q + 1'b1 : '0;
        stable_d = (differ && cnt_q == CNT_LAST) ? ~stable_q : stable_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q    <= 2'b11;
            stable_q  <= 1'b1;
            cnt_q     <= '0;
            pressed_q <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            cap_q     <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], key_n};
            stable_q  <= stable_d;
            cnt_q     <= cnt_d;
            pressed_q <= ~stable_q;
            press_q   <= ~stable_q & ~pressed_q;
            release_q <= stable_q & pressed_q;
            cap_q     <= press_q | (cap_q & ~clear_edge);
        end
    end
    assign pressed       = pressed_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign edge_capture  = cap_q;
endmodule

// File: rtl/key_debounce.sv
// key_debounce: NUM_KEYS independent pushbutton debouncers with press/release strobes and sticky press flags.
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] key_n,
    input  logic [NUM_KEYS-1:0] clear_edges,
    output logic [NUM_KEYS-1:0] pressed,
    output logic [NUM_KEYS-1:0] press_pulse,
    output logic [NUM_KEYS-1:0] release_pulse,
    output logic [NUM_KEYS-1:0] edge_capture
);
    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cell (
            .clk          (clk),
            .reset        (reset),
            .key_n        (key_n[k]),
            .clear_edge   (clear_edges[k]),
            .pressed      (pressed[k]),
            .press_pulse  (press_pulse[k]),
            .release_pulse(release_pulse[k]),
            .edge_capture (edge_capture[k])
        );
    end
endmodule
